rr_mux4x1: RTL
==============

# rr_mux4x1

Four-to-one round-robin multiplexer with valid/ready handshakes on every channel. It merges four producer streams onto one registered output and tags each beat with the index of its source channel. It is the merge side of the 1-to-4 demux path: the demux fans one stream out by `sel`, and this block collects streams back in, emitting `sel` for every beat.

## Interface
Parameters:
- `DATA_W`, default 8, width of each data beat.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  4  per-channel beat valid; bit i belongs to channel i.
- `in_data`  in  4*DATA_W  per-channel data; channel i at `[i*DATA_W +: DATA_W]`.
- `in_last`  in  4  per-channel end-of-packet flag.
- `in_ready`  out  4  per-channel accept.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DATA_W  output beat data.
- `out_sel`  out  2  source channel index of the output beat.
- `out_last`  out  1  copy of the accepted beat's `in_last`.
- `out_ready`  in  1  downstream accept.

## Operation
- A transfer occurs on a port in any cycle where valid and ready are both 1. Producers hold `in_data`/`in_last` stable while `in_valid` is 1 and not yet accepted.
- Round-robin pointer `ptr` (2 bits) gives the priority start. The grant goes to the first channel with `in_valid=1`, searching `ptr, ptr+1, …` modulo 4.
- Output stage is one register. `can_load = !out_valid || out_ready`.
- `in_ready[i] = can_load && (grant == i) && |in_valid`. At most one `in_ready` bit is high. `in_ready` does not depend on `in_valid[i]` of other channels once the grant is made.
- On acceptance from channel g:
  - the register loads `in_data[g]`, `in_last[g]`, and `out_sel = g`;
  - `out_valid` is set to 1;
  - `ptr` is set to `(g+1) mod 4`, wrapping from 3 to 0.
- If `out_valid && out_ready` and nothing is accepted, `out_valid` clears. The data, sel and last registers hold their values.
- Simultaneous output drain and input accept in the same cycle: the register reloads, `out_valid` stays 1, and there is no bubble.
- If no `in_valid` bit is set, `in_ready` is 0000 and `ptr` is unchanged.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`, `ptr=0`, lock cleared. Reset mid-transfer discards the held beat and any open lock. Inputs are not accepted in the reset cycle.

## Timing
- Latency from input acceptance to `out_valid` is 1 cycle.
- Throughput is 1 beat per cycle while `out_ready` stays 1.
- `in_ready` is combinational from `out_valid`, `out_ready`, `in_valid` and `ptr`/lock state. There is no combinational path from `in_data` to any output.
- Backpressure: while `out_valid=1` and `out_ready=0`, all `in_ready` bits are 0 and the outputs are held stable.

## Configuration
- `RR_MUX_PKT_LOCK_EN` defined: packet lock.
  - After accepting a beat with `in_last=0` from channel g, the grant stays locked to g. Other valid channels are ignored until a beat with `in_last=1` is accepted from g.
  - `ptr` advances to `(g+1) mod 4` only when that last beat is accepted.
  - While locked, an idle g (`in_valid[g]=0`) stalls the block; the lock is not broken.
- `RR_MUX_PKT_LOCK_EN` undefined: arbitration is per beat.
  - `in_last` is passed through as data only.
  - `ptr` advances on every accepted beat.

## Structure
- Package `rr_mux_pkg`:
  - `CH_N = 4`, `SEL_W = 2`;
  - `typedef logic [SEL_W-1:0] sel_t`;
  - function `rr_next(ptr, valid)` returning the granted index.
- Sub-module `rr_arb4`: combinational round-robin grant plus the registered `ptr` and lock state. Inputs are `in_valid`, `in_last`, and the accept strobe; outputs are `grant` (sel_t) and `any_valid`.
- Top level holds the output register and the ready logic.

## Test plan
- Reset with all `in_valid=1111` -> `out_valid=0`, `out_sel=0` and `in_ready=0000` in the reset cycle. After reset the first accept is from ch0, and `out_sel=0` appears 1 cycle later.
- All four channels valid continuously with `out_ready=1`, data A0/B1/C2/D3 -> `out_sel` sequence 0,1,2,3,0,… at one beat per cycle with matching data.
- Only ch2 valid, data 0x5A, `out_ready=0` for 3 cycles -> `out_valid=1`, `out_data=0x5A`, `out_sel=2` held stable; `in_ready=0000` during the stall. The beat drains on the cycle `out_ready` rises.
- `ptr=3` with ch0 and ch3 valid -> ch3 is granted, then `ptr` wraps to 0 and ch0 is granted next.
- Reset asserted while `out_valid=1` and stalled -> the next cycle shows `out_valid=0` and `ptr=0`. The stale beat is never emitted.
- With `RR_MUX_PKT_LOCK_EN`: ch1 sends a 3-beat packet (`in_last` 0,0,1) while ch2 is valid throughout -> output sel 1,1,1 and then 2. Without the macro, the same stimulus gives sel 1,2,1,2,1.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg
// Shared constants, types and the round-robin search helper for the
// four-to-one round-robin multiplexer (rr_mux4x1) and its arbiter (rr_arb4).
//   CH_N    number of producer channels
//   SEL_W   width of a channel index
//   sel_t   channel index type
//   rr_next first valid channel searching ptr, ptr+1, ... modulo CH_N
// ---------------------------------------------------------------------------
package rr_mux_pkg;

   localparam int CH_N  = 4;
   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   // Returns the first channel with valid set, starting the search at ptr.
   // When no channel is valid, ptr itself is returned; callers qualify the
   // result with an any-valid flag.
   function automatic sel_t rr_next(input sel_t ptr, input logic [CH_N-1:0] valid);
      sel_t idx;
      rr_next = ptr;
      // Walk from the farthest offset down so the nearest valid channel wins.
      for (int k = CH_N - 1; k >= 0; k--) begin
         idx = ptr + sel_t'(k);
         if (valid[idx]) rr_next = idx;
      end
   endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
// Round-robin arbiter for four channels: combinational grant, registered
// priority pointer and (optionally) packet lock state.
// Optional feature macro: RR_MUX_PKT_LOCK_EN (packet lock; holds the grant on
// one channel from its first accepted beat until its in_last beat).
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet flag
//   accept     a beat from channel 'grant' is taken this cycle
//   grant      granted channel index
//   any_valid  the granted channel has a beat to offer
// ---------------------------------------------------------------------------
module rr_arb4
   import rr_mux_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [CH_N-1:0] in_valid,
   input  logic [CH_N-1:0] in_last,
   input  logic            accept,
   output sel_t            grant,
   output logic            any_valid
);

   sel_t ptr_q, ptr_d;

`ifdef RR_MUX_PKT_LOCK_EN
   logic lock_q, lock_d;
   sel_t lock_sel_q, lock_sel_d;

   // While locked the grant is pinned; an idle locked channel stalls the
   // block instead of letting another channel in.
   always_comb begin
      grant     = lock_q ? lock_sel_q : rr_next(ptr_q, in_valid);
      any_valid = lock_q ? in_valid[lock_sel_q] : |in_valid;
   end

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      if (accept) begin
         if (in_last[grant]) begin
            ptr_d  = grant + 2'd1;
            lock_d = 1'b0;
         end else begin
            lock_d     = 1'b1;
            lock_sel_d = grant;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
      end
   end
`else
   // Per-beat arbitration: in_last does not affect the grant.
   logic unused_last;
   assign unused_last = ^in_last;

   always_comb begin
      grant     = rr_next(ptr_q, in_valid);
      any_valid = |in_valid;
   end

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = grant + 2'd1;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

endmodule : rr_arb4

// File: rtl/rr_mux4x1.sv
// ---------------------------------------------------------------------------
// rr_mux4x1
// Four-to-one round-robin multiplexer with valid/ready on every channel and a
// single registered output stage. Each output beat carries the index of its
// source channel on out_sel.
// Optional feature macro: RR_MUX_PKT_LOCK_EN (packet lock, see rr_arb4).
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   per-channel beat valid (bit i = channel i)
//   in_data    per-channel data, channel i at [i*DATA_W +: DATA_W]
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel accept (one-hot or zero)
//   out_valid  output beat valid
//   out_data   output beat data
//   out_sel    source channel of the output beat
//   out_last   in_last of the accepted beat
//   out_ready  downstream accept
// ---------------------------------------------------------------------------
module rr_mux4x1
   import rr_mux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CH_N-1:0]        in_valid,
   input  logic [CH_N*DATA_W-1:0] in_data,
   input  logic [CH_N-1:0]        in_last,
   output logic [CH_N-1:0]        in_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output sel_t                   out_sel,
   output logic                   out_last,
   input  logic                   out_ready
);

   sel_t              grant;
   logic              any_valid;
   logic              can_load;
   logic              accept;
   logic [DATA_W-1:0] grant_data;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   sel_t              out_sel_q,   out_sel_d;
   logic              out_last_q,  out_last_d;

   rr_arb4 u_arb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .accept    (accept),
      .grant     (grant),
      .any_valid (any_valid)
   );

   // The register may load when empty or when its beat leaves this cycle,
   // which gives back-to-back beats with no bubble.
   assign can_load   = !out_valid_q || out_ready;
   // Nothing is taken in the reset cycle, so ready is held low there too.
   assign accept     = can_load && any_valid && !rst;
   assign in_ready   = accept ? (CH_N'(1) << grant) : '0;
   assign grant_data = in_data[32'(grant) * DATA_W +: DATA_W];

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_last_d  = out_last_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_sel_d   = grant;
         out_last_d  = in_last[grant];
      end else if (out_ready) begin
         // Drained with nothing new: payload registers keep their values.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_last  = out_last_q;

endmodule : rr_mux4x1
